mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 20 ++
 rtl/mem_responder_if.sv | 23 ++
 rtl/mem_responder_tracker.sv | 70 +++++++
 rtl/mem_responder.sv | 83 ++++++++
 tb/tb_mem_responder.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: word width, byte/word types, FSM states.
// Optional build macro used elsewhere in this slice: MEM_TRACE_EN.
package mem_pkg;

  localparam int XLEN = 32;

  typedef logic [7:0] byte_t;
  typedef byte_t word_bytes_t [0:3];

  typedef enum logic {
    WAIT  = 1'b0,
    READY = 1'b1
  } resp_state_e;

  // Byte [0] is the lowest address, so it lands in the least significant bits.
  function automatic logic [31:0] pack_word(input word_bytes_t w);
    return {w[3], w[2], w[1], w[0]};
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Word-wide memory port between the core (master) and the memory responder (slave).
interface mem_responder_if;
  import mem_pkg::*;

  // Request is {mem_addr, mem_write_en, mem_data_in}, held stable by the master until
  // mem_ready is seen high; mem_data_out may only be consumed while mem_ready is 1.
  logic [XLEN-1:0] mem_addr;
  word_bytes_t     mem_data_in;
  logic            mem_write_en;
  word_bytes_t     mem_data_out;
  logic            mem_ready;

  modport master (
    output mem_addr, mem_data_in, mem_write_en,
    input  mem_data_out, mem_ready
  );

  modport slave (
    input  mem_addr, mem_data_in, mem_write_en,
    output mem_data_out, mem_ready
  );

endinterface

// File: rtl/mem_responder_tracker.sv
// Request tracker: remembers the previous request, restarts the latency count on any
// change, and emits a single do_access strobe per stable window.
module mem_req_tracker
  import mem_pkg::*;
#(
  parameter int LATENCY = 4
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [XLEN-3:0] addr_word,
  input  logic            we,
  input  logic [31:0]     wdata,
  output logic            do_access,
  output logic            ready,
  output resp_state_e     state
);

  localparam int            CW      = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LATENCY);

  logic [XLEN-3:0] prev_addr;
  logic            prev_we;
  logic [31:0]     prev_wdata;
  logic [CW-1:0]   cnt;
  logic            changed;

  // Write data only matters for write requests.
  assign changed = (addr_word != prev_addr) || (we != prev_we) ||
                   (we && (wdata != prev_wdata));

  assign do_access = (state == WAIT) && !changed && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      prev_addr  <= '0;
      prev_we    <= 1'b0;
      prev_wdata <= '0;
      cnt        <= '0;
      ready      <= 1'b0;
      state      <= WAIT;
    end else begin
      prev_addr  <= addr_word;
      prev_we    <= we;
      prev_wdata <= wdata;
      if (changed) begin
        cnt   <= '0;
        ready <= 1'b0;
        state <= WAIT;
      end else begin
        case (state)
          WAIT: begin
            if (cnt == CNT_MAX) begin
              ready <= 1'b1;
              state <= READY;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          READY: begin
            ready <= 1'b1;
          end
          default: begin
            state <= WAIT;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: byte array with word access and fixed latency.
// Define MEM_TRACE_EN to print one line per committed access.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 65536,
  parameter int LATENCY     = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  mem_responder_if.slave   bus,
  output resp_state_e      state_dbg
);

  localparam int AW = $clog2(DEPTH_BYTES);

  byte_t        storage [0:DEPTH_BYTES-1];
  logic [AW-1:0] base;
  logic [31:0]  wdata_packed;
  word_bytes_t  rd_bytes;
  word_bytes_t  data_q;
  logic         do_access;
  logic         ready;
  logic         unused_addr_lsbs;

  // Out-of-range addresses wrap because only the low AW bits index storage.
  assign base             = {bus.mem_addr[AW-1:2], 2'b00};
  assign wdata_packed     = pack_word(bus.mem_data_in);
  assign unused_addr_lsbs = ^bus.mem_addr[1:0];

  mem_req_tracker #(
    .LATENCY (LATENCY)
  ) u_tracker (
    .clk       (clk),
    .rst_b     (rst_b),
    .addr_word (bus.mem_addr[XLEN-1:2]),
    .we        (bus.mem_write_en),
    .wdata     (wdata_packed),
    .do_access (do_access),
    .ready     (ready),
    .state     (state_dbg)
  );

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rd_bytes[i] = storage[base + AW'(i)];
    end
  end

  // Storage has no reset; contents survive rst_b.
  always_ff @(posedge clk) begin
    if (do_access && bus.mem_write_en) begin
      for (int i = 0; i < 4; i++) begin
        storage[base + AW'(i)] <= bus.mem_data_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= '0;
      end
    end else if (do_access) begin
      for (int i = 0; i < 4; i++) begin
        data_q[i] <= bus.mem_write_en ? bus.mem_data_in[i] : rd_bytes[i];
      end
    end
  end

  assign bus.mem_data_out = data_q;
  assign bus.mem_ready    = ready;

`ifdef MEM_TRACE_EN
  always @(posedge clk) begin
    if (rst_b && do_access) begin
      $display("%s addr=%h data=%h t=%0t", bus.mem_write_en ? "W" : "R", bus.mem_addr,
               bus.mem_write_en ? wdata_packed : pack_word(rd_bytes), $time);
    end
  end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed + random bench for mem_responder against a stable-window reference model.
module tb_mem_responder;
  import mem_pkg::*;

  localparam int DEPTH = 65536;
  localparam int LAT   = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  mem_responder_if bus ();
  resp_state_e     state_dbg;

  logic [XLEN-1:0] d_addr;
  logic            d_we;
  logic [31:0]     d_wd;

  assign bus.mem_addr       = d_addr;
  assign bus.mem_write_en   = d_we;
  assign bus.mem_data_in[0] = d_wd[7:0];
  assign bus.mem_data_in[1] = d_wd[15:8];
  assign bus.mem_data_in[2] = d_wd[23:16];
  assign bus.mem_data_in[3] = d_wd[31:24];

  mem_responder #(
    .DEPTH_BYTES (DEPTH),
    .LATENCY     (LAT)
  ) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- reference model ----------------
  logic [7:0]      ref_mem   [0:DEPTH-1];
  bit              ref_known [0:DEPTH-1];
  logic [XLEN-1:0] p_addr;
  logic            p_we;
  logic [31:0]     p_wd;
  int              stable;
  logic            exp_ready;
  logic [31:0]     exp_data;
  bit              exp_known;

  int total = 0;
  int bad   = 0;

  task automatic model_reset();
    p_addr    = '0;
    p_we      = 1'b0;
    p_wd      = '0;
    stable    = 0;
    exp_ready = 1'b0;
    exp_data  = '0;
    exp_known = 1'b1;
  endtask

  // One rising edge: count consecutive edges with an unchanged request; the
  // (LAT+1)-th such edge is the single commit of the window.
  task automatic model_edge();
    bit          chg;
    int unsigned idx;
    chg = (d_addr[XLEN-1:2] != p_addr[XLEN-1:2]) || (d_we != p_we) ||
          (d_we && (d_wd != p_wd));
    p_addr = d_addr;
    p_we   = d_we;
    p_wd   = d_wd;
    if (chg) begin
      stable    = 0;
      exp_ready = 1'b0;
    end else begin
      stable++;
      if (stable == LAT + 1) begin
        idx = (d_addr % DEPTH) & ~32'd3;
        if (d_we) begin
          for (int b = 0; b < 4; b++) begin
            ref_mem[idx + b]   = d_wd[8*b +: 8];
            ref_known[idx + b] = 1'b1;
          end
          exp_data  = d_wd;
          exp_known = 1'b1;
        end else begin
          exp_known = 1'b1;
          for (int b = 0; b < 4; b++) begin
            exp_data[8*b +: 8] = ref_mem[idx + b];
            if (!ref_known[idx + b]) exp_known = 1'b0;
          end
        end
        exp_ready = 1'b1;
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check("ready", 32'(bus.mem_ready), 32'(exp_ready));
    check("state", 32'(state_dbg == READY), 32'(exp_ready));
    if (exp_known) check("data", pack_word(bus.mem_data_out), exp_data);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    if (rst_b) model_edge();
    #1;
    check_outputs();
  endtask

  task automatic hold(input logic [XLEN-1:0] a, input logic we, input logic [31:0] wd,
                      input int n);
    d_addr = a;
    d_we   = we;
    d_wd   = wd;
    repeat (n) tick();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    for (int i = 0; i < DEPTH; i++) ref_known[i] = 1'b0;
    d_addr = '0;
    d_we   = 1'b0;
    d_wd   = '0;
    rst_b  = 1'b0;
    model_reset();
    repeat (2) tick();
    rst_b = 1'b1;

    // Read of 0 right after reset: first edge counts.
    hold(32'h0, 1'b0, 32'h0, 6);

    // Write then read back.
    hold(32'h100, 1'b1, 32'hDEADBEEF, 6);
    hold(32'h100, 1'b0, 32'h0, 6);

    // Address change mid-wait restarts the count.
    hold(32'h0, 1'b0, 32'h0, 6);
    hold(32'h100, 1'b0, 32'h0, 3);
    hold(32'h104, 1'b0, 32'h0, 6);
    hold(32'h100, 1'b0, 32'h0, 6);
    hold(32'h102, 1'b0, 32'h0, 4);

    // Data change mid-wait: only the later data is stored; long READY hold.
    hold(32'h300, 1'b1, 32'h11111111, 3);
    hold(32'h300, 1'b1, 32'h22222222, 20);
    hold(32'h300, 1'b0, 32'h0, 6);

    // Reset during a pending write leaves storage untouched.
    hold(32'h200, 1'b1, 32'h12345678, 6);
    hold(32'h200, 1'b1, 32'hAAAA5555, 2);
    rst_b = 1'b0;
    #1;
    model_reset();
    check_outputs();
    d_we = 1'b0;
    d_wd = '0;
    repeat (2) tick();
    rst_b = 1'b1;
    hold(32'h200, 1'b0, 32'h0, 6);

    // Address wrap.
    hold(DEPTH + 32'h8, 1'b1, 32'hCAFEF00D, 6);
    hold(32'h8, 1'b0, 32'h0, 6);

    // Random requests over a small window, including wrapped aliases and byte offsets.
    for (int n = 0; n < 60; n++) begin
      hold(32'h400 + (32'($urandom_range(0, 7)) << 2) + 32'($urandom_range(0, 3)) +
             ($urandom_range(0, 1) != 0 ? 32'(DEPTH) : 32'h0),
           1'($urandom_range(0, 1)), $urandom, $urandom_range(1, 8));
    end
    hold(32'h400, 1'b0, 32'h0, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
